mux_sel_arbiter: RTL
====================

# mux_sel_arbiter

Round-robin arbiter that generates the select for the 4:1 MUX stage (`Sel[1:0]`) from four request lines. It grants one requester at a time, holds the grant while that requester keeps requesting, and forces rotation after a bounded hold time so no source starves. It sits directly upstream of the MUX. Its `Sel` output drives the MUX select, and `valid` qualifies the MUX output `y*` for downstream logic.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner while other requests are pending. Legal range is ≥1.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: request per MUX input; `req[i]` asks for `In[i]` to be selected.
- `Sel` output 2: binary index of current owner; drives MUX `Sel`.
- `gnt` output 4: one-hot grant, `gnt == (1<<Sel)` when `valid`, else 0.
- `valid` output 1: a grant is active, so the MUX output is meaningful.
- `sel_chg` output 1: one-cycle pulse on the cycle `Sel`/owner changes to a new granted index.

## Operation
- **State**
  - FSM with states IDLE and GRANT.
  - `ptr[1:0]` is the round-robin start index.
  - `hold_cnt` is `$clog2(MAX_HOLD+1)` bits and saturates at `MAX_HOLD`.
- **Winner search**: `pick(start)` returns the first `i` with `req[i]=1` in the order start, start+1, … mod 4. The index wraps 3→0.
- **IDLE**
  - `req==0`: stay in IDLE.
  - Otherwise: owner ← `pick(ptr)`, enter GRANT, `hold_cnt` ← 1.
- **GRANT, owner k**
  - `req[k]==0` with other requests: release, owner ← `pick(k+1)` directly, with no idle cycle. `hold_cnt` ← 1.
  - `req[k]==0` with no requests: go to IDLE. `ptr` ← k+1.
  - `req[k]==1`, `hold_cnt==MAX_HOLD`, and some other `req[j]`, j≠k: forced rotation, owner ← `pick(k+1)`, `hold_cnt` ← 1.
  - Otherwise: keep owner, `hold_cnt` ← min(`hold_cnt`+1, `MAX_HOLD`).
- **Pointer update**: every time a new owner k is granted, `ptr` ← k+1 mod 4.
- **sel_chg**: asserted for one cycle whenever a grant transition occurs (IDLE→GRANT, or owner switch). Re-granting the same index after IDLE also pulses.
- **Sel while idle**: `Sel` holds its last value in IDLE, so the MUX input stays stable. `gnt` is 0 and `valid` is 0.
- **Forced rotation with no other requester**: if the only remaining requester is k, the owner stays k and there is no pulse.

## Timing
- All outputs are registered.
- **Reset values**: `Sel=0`, `gnt=0`, `valid=0`, `sel_chg=0`, `ptr=0`, `hold_cnt=0`, state IDLE.
- **Reset assertion**: takes effect immediately, asynchronously, including mid-grant.
- **First edge after reset release**: behaves as IDLE.
- **Latency**:
  - `req` sampled at edge N → `gnt`/`Sel`/`valid`/`sel_chg` valid after edge N.
  - One cycle from request to grant.
  - One cycle from owner drop to new grant or to `valid=0`.
- **Hold bound**: with contention, an owner holds at most `MAX_HOLD` consecutive cycles. The switch is visible on the following edge.
- **Worst-case wait**: a pending requester waits at most 3×`MAX_HOLD`+1 cycles.
- **Simultaneous events**:
  - Owner drop coinciding with hold expiry is treated as a drop.
  - Requests arriving in the same cycle are resolved purely by `pick` order.
- **No combinational paths**: none from `req` to any output.

## Test plan
- **Reset check**: assert `rst` mid-grant (owner 2, `valid=1`) → outputs immediately `Sel=0`, `gnt=0000`, `valid=0`, `sel_chg=0`. After release, `req=0100` → `Sel=2`, `gnt=0100`, `valid=1`, `sel_chg=1` one cycle later.
- **Rotation order**: `req=1111` held, `MAX_HOLD=8` → grants 0,1,2,3,0 each lasting exactly 8 cycles. `sel_chg` pulses on every switch.
- **Sole requester**: `req=0001` held for 30 cycles → owner stays 0, `valid=1` throughout, one `sel_chg` pulse only, `hold_cnt` saturates at 8.
- **Early release**: owner 1 with `req=1010`; drop to `req=1000` → next cycle `Sel=3`, `gnt=1000`, no idle cycle. Then `req=0000` → `valid=0`, `gnt=0000`, `Sel` stays 3.
- **Wrap-around**: owner 3, `req=1001`, hold expires → `Sel=0`. Later, from IDLE with `ptr=1`, `req=0011` → `Sel=1`.
- **Reference-model check**: randomized `req` for 2000 cycles, compared against a cycle-accurate model. Also assert `gnt` is one-hot or zero, and that `valid=1` implies `req[Sel]` was high at the previous edge.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter producing the 4:1 MUX select.
// Bounded hold time forces rotation so no requester starves.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] Sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       sel_chg
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] ONE  = HW'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      gnt_q, gnt_d;
  logic            chg_q, chg_d;

  logic [3:0]      others;
  logic [1:0]      nxt;
  logic [1:0]      new_idx;
  logic            grant_new;

  // First requester at or after start, wrapping 3 -> 0.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] start
  );
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Next-state: grant, release, forced rotation, hold counting.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    chg_d     = 1'b0;
    grant_new = 1'b0;
    new_idx   = sel_q;
    others    = req & ~(4'b0001 << sel_q);
    nxt       = pick(req, sel_q + 2'd1);
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_new = 1'b1;
          new_idx   = pick(req, ptr_q);
        end
      end
      GRANT: begin
        unique case (1'b1)
          !req[sel_q] && |others: begin
            grant_new = 1'b1;
            new_idx   = nxt;
          end
          !req[sel_q] && !(|others): begin
            state_d = IDLE;
            ptr_d   = sel_q + 2'd1;
          end
          req[sel_q] && hold_q == HMAX && |others: begin
            grant_new = 1'b1;
            new_idx   = nxt;
          end
          default: begin
            if (hold_q != HMAX) hold_d = hold_q + ONE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (grant_new) begin
      state_d = GRANT;
      sel_d   = new_idx;
      ptr_d   = new_idx + 2'd1;
      hold_d  = ONE;
      chg_d   = 1'b1;
    end
    gnt_d = (state_d == GRANT) ? (4'b0001 << sel_d) : 4'b0000;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      chg_q   <= chg_d;
    end
  end

  assign Sel     = sel_q;
  assign gnt     = gnt_q;
  assign valid   = (state_q == GRANT);
  assign sel_chg = chg_q;

endmodule
